dcache_req_arbiter: RTL and testbench

//  Arbitrates the single dcache port between the two execute-stage memory pipes of the dual-issue backend.

---
 rtl/dcache_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_dcache_req_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_arbiter.sv
// Shares the single dcache port between the two execute-stage memory pipes.
// The older pipe 0 is served first. Pipe 1 is served after pipe 0's data returns. A flush drains in-flight data.
module dcache_req_arbiter #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    input  logic [2*STRB_W-1:0] req_wstrb,
    output logic                dc_valid,
    output logic                dc_we,
    output logic [ADDR_W-1:0]   dc_addr,
    output logic [DATA_W-1:0]   dc_wdata,
    output logic [STRB_W-1:0]   dc_wstrb,
    input  logic                dc_addr_ok,
    input  logic                dc_data_ok,
    input  logic [DATA_W-1:0]   dc_rdata,
    output logic [1:0]          resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                pause_mem
);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DRAIN
    } state_t;

    state_t state, next_state;

    logic              held_we    [2];
    logic [ADDR_W-1:0] held_addr  [2];
    logic [DATA_W-1:0] held_wdata [2];
    logic [STRB_W-1:0] held_wstrb [2];
    logic              held_valid1;

    logic capture;
    logic sel;

    assign capture = (state == IDLE) && !flush && (req_valid != 2'b00);
    assign sel     = (state == REQ1) || (state == WAIT1);

    // Both pipes are latched together in IDLE and then frozen until the block returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            held_valid1 <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                held_we[i]    <= 1'b0;
                held_addr[i]  <= '0;
                held_wdata[i] <= '0;
                held_wstrb[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (capture) begin
                held_valid1 <= req_valid[1];
                for (int i = 0; i < 2; i++) begin
                    held_we[i]    <= req_we[i];
                    held_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
                    held_wdata[i] <= req_wdata[i*DATA_W +: DATA_W];
                    held_wstrb[i] <= req_wstrb[i*STRB_W +: STRB_W];
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        dc_valid   = 1'b0;
        dc_we      = 1'b0;
        dc_addr    = '0;
        dc_wdata   = '0;
        dc_wstrb   = '0;
        resp_valid = 2'b00;
        resp_rdata = '0;
        pause_mem  = 1'b0;

        case (state)
            IDLE: begin
                if (capture) begin
                    pause_mem  = rst;
                    next_state = req_valid[0] ? REQ0 : REQ1;
                end
            end

            REQ0, REQ1: begin
                dc_valid  = 1'b1;
                dc_we     = held_we[sel];
                dc_addr   = held_addr[sel];
                dc_wdata  = held_wdata[sel];
                dc_wstrb  = held_wstrb[sel];
                pause_mem = 1'b1;
                // An accepted request must still have its data drained, even when it is flushed.
                if (flush) begin
                    next_state = dc_addr_ok ? DRAIN : IDLE;
                end else if (dc_addr_ok) begin
                    next_state = (state == REQ0) ? WAIT0 : WAIT1;
                end
            end

            WAIT0, WAIT1: begin
                pause_mem = 1'b1;
                if (dc_data_ok) begin
                    if (flush) begin
                        next_state = IDLE;
                        pause_mem  = 1'b0;
                    end else begin
                        resp_valid[sel] = 1'b1;
                        resp_rdata      = dc_rdata;
                        if ((state == WAIT0) && held_valid1) begin
                            next_state = REQ1;
                        end else begin
                            next_state = IDLE;
                            pause_mem  = 1'b0;
                        end
                    end
                end else if (flush) begin
                    next_state = DRAIN;
                end
            end

            DRAIN: begin
                pause_mem = 1'b1;
                if (dc_data_ok) begin
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    a_data_ok_expected: assert property (
        @(posedge clk) disable iff (!rst)
        dc_data_ok |-> ((state == WAIT0) || (state == WAIT1) || (state == DRAIN))
    );

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Randomized bench for dcache_req_arbiter, checked against a transaction-level queue model.
module tb_dcache_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        dc_valid;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wstrb;
    logic        dc_addr_ok = 1'b0;
    logic        dc_data_ok = 1'b0;
    logic [31:0] dc_rdata = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        pause_mem;

    dcache_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .dc_valid   (dc_valid),
        .dc_we      (dc_we),
        .dc_addr    (dc_addr),
        .dc_wdata   (dc_wdata),
        .dc_wstrb   (dc_wstrb),
        .dc_addr_ok (dc_addr_ok),
        .dc_data_ok (dc_data_ok),
        .dc_rdata   (dc_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .pause_mem  (pause_mem)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: a list of pipes still to be served plus transaction flags.
    int          pend[$];
    bit          busy = 0;
    bit          outstanding = 0;
    bit          draining = 0;
    logic        h_we    [2];
    logic [31:0] h_addr  [2];
    logic [31:0] h_wdata [2];
    logic [3:0]  h_wstrb [2];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic modelReset();
        pend.delete();
        busy = 0;
        outstanding = 0;
        draining = 0;
    endtask

    task automatic randomizeInputs();
        req_valid  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        req_we     = 2'($urandom_range(0, 3));
        req_addr   = {$urandom(), $urandom()};
        req_wdata  = {$urandom(), $urandom()};
        req_wstrb  = 8'($urandom_range(0, 255));
        flush      = ($urandom_range(0, 15) == 0);
        dc_addr_ok = 1'($urandom_range(0, 1));
        dc_data_ok = (busy && (draining || outstanding)) ? ($urandom_range(0, 9) < 4) : 1'b0;
        dc_rdata   = $urandom();
    endtask

    // Checks the current cycle's outputs, advances the model, then steps to posedge+1.
    task automatic applyStimulus();
        logic       exp_valid;
        logic       exp_pause;
        logic [1:0] exp_resp;
        int         p;
        #2;
        exp_valid = 0;
        exp_pause = 0;
        exp_resp  = 2'b00;
        p = (pend.size() > 0) ? pend[0] : 0;
        if (!busy) exp_pause = !flush && (req_valid != 2'b00);
        else if (draining) exp_pause = 1;
        else if (!outstanding) begin
            exp_valid = 1;
            exp_pause = 1;
        end else begin
            exp_pause = !(dc_data_ok && (flush || pend.size() == 1));
            if (dc_data_ok && !flush) exp_resp[p] = 1'b1;
        end

        checkOutput("dc_valid", 64'(dc_valid), 64'(exp_valid));
        if (exp_valid) begin
            checkOutput("dc_we", 64'(dc_we), 64'(h_we[p]));
            checkOutput("dc_addr", 64'(dc_addr), 64'(h_addr[p]));
            checkOutput("dc_wdata", 64'(dc_wdata), 64'(h_wdata[p]));
            checkOutput("dc_wstrb", 64'(dc_wstrb), 64'(h_wstrb[p]));
        end
        checkOutput("resp_valid", 64'(resp_valid), 64'(exp_resp));
        if (exp_resp != 2'b00 && !h_we[p]) checkOutput("resp_rdata", 64'(resp_rdata), 64'(dc_rdata));
        checkOutput("pause_mem", 64'(pause_mem), 64'(exp_pause));

        if (!busy) begin
            if (!flush && req_valid != 2'b00) begin
                for (int i = 0; i < 2; i++) begin
                    h_we[i]    = req_we[i];
                    h_addr[i]  = req_addr[i*32 +: 32];
                    h_wdata[i] = req_wdata[i*32 +: 32];
                    h_wstrb[i] = req_wstrb[i*4 +: 4];
                    if (req_valid[i]) pend.push_back(i);
                end
                busy = 1;
                outstanding = 0;
            end
        end else if (draining) begin
            if (dc_data_ok) modelReset();
        end else if (!outstanding) begin
            if (flush) begin
                if (dc_addr_ok) draining = 1;
                else modelReset();
            end else if (dc_addr_ok) outstanding = 1;
        end else begin
            if (dc_data_ok) begin
                if (flush) modelReset();
                else begin
                    void'(pend.pop_front());
                    outstanding = 0;
                    if (pend.size() == 0) modelReset();
                end
            end else if (flush) draining = 1;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        #2;
        rst = 1'b0;
        dc_data_ok = 1'b0;
        #1;
        checkOutput("rst_dc_valid", 64'(dc_valid), 64'd0);
        checkOutput("rst_dc_fields", {dc_we, dc_addr, dc_wstrb}, 64'd0);
        checkOutput("rst_dc_wdata", 64'(dc_wdata), 64'd0);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        checkOutput("rst_pause", 64'(pause_mem), 64'd0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_dc_valid", 64'(dc_valid), 64'd0);
        checkOutput("init_pause", 64'(pause_mem), 64'd0);
        rst = 1'b1;
        modelReset();

        // Single load from pipe 0: capture, request, data.
        req_valid = 2'b01; req_we = 2'b00; req_addr = {32'h0, 32'h1000};
        flush = 0; dc_addr_ok = 1; dc_data_ok = 0;
        applyStimulus();
        req_valid = 2'b00;
        applyStimulus();
        dc_data_ok = 1; dc_rdata = 32'hDEADBEEF;
        applyStimulus();
        dc_data_ok = 0;
        applyStimulus();

        // Dual load, then reset while pipe 1 waits for its data.
        req_valid = 2'b11; req_addr = {32'h20, 32'h10}; dc_addr_ok = 1;
        applyStimulus();
        req_valid = 2'b00;
        applyStimulus();
        dc_data_ok = 1; dc_rdata = 32'hA;
        applyStimulus();
        dc_data_ok = 0;
        applyStimulus();
        dc_addr_ok = 0;
        doReset();
        req_valid = 2'b00;
        repeat (3) applyStimulus();

        for (int n = 0; n < 4000; n++) begin
            randomizeInputs();
            if (n % 500 == 499) doReset();
            else applyStimulus();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
